sram_bus_uart_responder: RTL and testbench

//  Memory-mapped UART peripheral. It responds as a target on the asynchronous SRAM-style RAM bus
//  (EN/OE/WE/Addr/Data) that the CPU memory controller drives. It decodes two addresses: DATA and

---
 rtl/sram_bus_uart_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_sram_bus_uart_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_uart_responder.sv
// Memory-mapped UART target on the asynchronous SRAM-style bus: DATA/STATUS registers,
// TX FIFO feeding an 8N1 serializer, and an RX FIFO filled by the serial front end.
module sram_bus_uart_responder #(
    parameter logic [15:0] BASE_ADDR    = 16'hBF00,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramEN,
    input  logic        ramOE,
    input  logic        ramWE,
    input  logic [15:0] ramAddr,
    inout  wire  [15:0] ramData,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        txd,
    output logic        tx_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

    // Bus strobe decode
    logic hit_data_c, hit_stat_c;
    logic rd_data_act_c, rd_stat_act_c, wr_act_c;

    assign hit_data_c    = (ramAddr == BASE_ADDR);
    assign hit_stat_c    = (ramAddr == (BASE_ADDR + 16'd1));
    assign rd_data_act_c = !ramEN && !ramOE && ramWE && hit_data_c;
    assign rd_stat_act_c = !ramEN && !ramOE && ramWE && hit_stat_c;
    assign wr_act_c      = !ramEN && !ramWE && (hit_data_c || hit_stat_c);

    logic       rd_data_q, rd_stat_q, wr_q;
    logic       wr_is_data_q;
    logic [7:0] wr_byte_q;

    // Side effects fire on the falling edge of each strobe, once per strobe
    logic rd_data_end_c, rd_stat_end_c, wr_commit_c;
    assign rd_data_end_c = rd_data_q && !rd_data_act_c;
    assign rd_stat_end_c = rd_stat_q && !rd_stat_act_c;
    assign wr_commit_c   = wr_q && !wr_act_c && wr_is_data_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_q    <= 1'b0;
            rd_stat_q    <= 1'b0;
            wr_q         <= 1'b0;
            wr_is_data_q <= 1'b0;
            wr_byte_q    <= 8'h00;
        end else begin
            rd_data_q <= rd_data_act_c;
            rd_stat_q <= rd_stat_act_c;
            wr_q      <= wr_act_c;
            if (wr_act_c) begin
                wr_is_data_q <= hit_data_c;
                wr_byte_q    <= ramData[7:0];
            end
        end
    end

    // FIFO pointers and storage
    logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];

    logic tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
    logic tx_pop_c, tx_push_c, rx_pop_c, rx_push_c;
    logic [7:0] tx_head_c, rx_head_c;

    assign tx_empty_c = (tx_wp_q == tx_rp_q);
    assign rx_empty_c = (rx_wp_q == rx_rp_q);
    assign tx_full_c  = (tx_wp_q[PTR_W] != tx_rp_q[PTR_W]) &&
                        (tx_wp_q[PTR_W-1:0] == tx_rp_q[PTR_W-1:0]);
    assign rx_full_c  = (rx_wp_q[PTR_W] != rx_rp_q[PTR_W]) &&
                        (rx_wp_q[PTR_W-1:0] == rx_rp_q[PTR_W-1:0]);
    assign tx_head_c  = tx_mem_q[tx_rp_q[PTR_W-1:0]];
    assign rx_head_c  = rx_mem_q[rx_rp_q[PTR_W-1:0]];

    assign rx_pop_c  = rd_data_end_c && !rx_empty_c;
    assign rx_push_c = rx_valid && (!rx_full_c || rx_pop_c);
    assign tx_push_c = wr_commit_c && (!tx_full_c || tx_pop_c);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (tx_push_c) tx_wp_q <= tx_wp_q + PW'(1);
            if (tx_pop_c)  tx_rp_q <= tx_rp_q + PW'(1);
            if (rx_push_c) rx_wp_q <= rx_wp_q + PW'(1);
            if (rx_pop_c)  rx_rp_q <= rx_rp_q + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push_c) tx_mem_q[tx_wp_q[PTR_W-1:0]] <= wr_byte_q;
        if (rx_push_c) rx_mem_q[rx_wp_q[PTR_W-1:0]] <= rx_data;
    end

    // Sticky error flags; a new event in the clearing cycle wins over the clear
    logic tx_ovf_q, rx_ovr_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            if (rd_stat_end_c) begin
                tx_ovf_q <= 1'b0;
                rx_ovr_q <= 1'b0;
            end
            if (wr_commit_c && tx_full_c && !tx_pop_c) tx_ovf_q <= 1'b1;
            if (rx_valid && rx_full_c && !rx_pop_c)    rx_ovr_q <= 1'b1;
        end
    end

    // Read data is driven combinationally for the whole strobe
    logic [15:0] rd_word_c;

    always_comb begin
        rd_word_c = 16'h0000;
        if (rd_data_act_c) begin
            rd_word_c = rx_empty_c ? 16'h0000 : {8'h00, rx_head_c};
        end else if (rd_stat_act_c) begin
            rd_word_c = {12'h000, rx_ovr_q, tx_ovf_q, !rx_empty_c, !tx_full_c};
        end
    end

    assign ramData = (RST && (rd_data_act_c || rd_stat_act_c)) ? rd_word_c : 16'hzzzz;

    // TX serializer
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             baud_done_c;

    assign baud_done_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_pop_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!tx_empty_c) begin
                    tx_pop_c = 1'b1;
                    shift_d  = tx_head_c;
                    cnt_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_done_c) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done_c) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done_c) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // txd follows the current state one clock later; busy tracks the state register exactly
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != S_IDLE);
        unique case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[idx_q];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_sram_bus_uart_responder.sv
// Directed bench for sram_bus_uart_responder: vector table for bus/RX behaviour, plus
// hand-written sequences for frame timing, TX overflow, RX overrun, long strobes and reset.
module tb_sram_bus_uart_responder;

    localparam int unsigned CPB = 4;
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_RX = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_en, ram_oe, ram_we;
    logic [15:0] ram_addr;
    tri1  [15:0] ram_data;
    logic        tb_drv;
    logic [15:0] tb_dout;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        txd, tx_busy;

    assign ram_data = tb_drv ? tb_dout : 16'hzzzz;

    sram_bus_uart_responder #(
        .BASE_ADDR   (16'hBF00),
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .ramEN   (ram_en),
        .ramOE   (ram_oe),
        .ramWE   (ram_we),
        .ramAddr (ram_addr),
        .ramData (ram_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] wdat;
        logic [15:0] exp;
        bit          expz;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_z(input string name, input logic [15:0] act);
        n_tests++;
        if (!(act === 16'hzzzz || act === 16'hffff)) begin
            n_fail++;
            $display("FAIL %s: got %h, expected undriven bus", name, act);
        end
    endtask

    // All bus tasks start and end just after a falling clock edge
    task automatic bus_read(input logic [15:0] addr, input int cycles, output logic [15:0] d);
        ram_addr = addr;
        ram_en   = 1'b0;
        ram_oe   = 1'b0;
        ram_we   = 1'b1;
        repeat (cycles) @(negedge clk);
        d      = ram_data;
        ram_en = 1'b1;
        ram_oe = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        ram_addr = addr;
        tb_dout  = data;
        tb_drv   = 1'b1;
        ram_en   = 1'b0;
        ram_oe   = 1'b1;
        ram_we   = 1'b0;
        @(negedge clk);
        ram_en = 1'b1;
        ram_we = 1'b1;
        tb_drv = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Serial line monitor: decodes 8N1 frames into a queue
    logic [7:0] rx_q [$];
    int         stop_err = 0;
    bit         mon_en   = 1'b1;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txd === 1'b0) begin
                repeat (CPB + CPB / 2 - 1) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = txd;
                    if (k < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                if (txd !== 1'b1) stop_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic        txs [200];
        int          busy_cnt;
        int          first;
        int          bad;
        int          lows;
        logic        e;
        logic [7:0]  sent [5];

        rst_n    = 1'b0;
        ram_en   = 1'b1;
        ram_oe   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 16'h0000;
        tb_drv   = 1'b0;
        tb_dout  = 16'h0000;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        vecs[0]  = '{OP_RD, 16'hBF01, 16'h0000, 16'h0001, 1'b0};
        vecs[1]  = '{OP_RD, 16'hBF05, 16'h0000, 16'h0000, 1'b1};
        vecs[2]  = '{OP_RD, 16'hBF00, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{OP_WR, 16'hBF01, 16'h00FF, 16'h0000, 1'b0};
        vecs[4]  = '{OP_WR, 16'hBF05, 16'h00AA, 16'h0000, 1'b0};
        vecs[5]  = '{OP_RD, 16'hBF01, 16'h0000, 16'h0001, 1'b0};
        vecs[6]  = '{OP_RX, 16'h0000, 16'h00A5, 16'h0000, 1'b0};
        vecs[7]  = '{OP_RX, 16'h0000, 16'h003C, 16'h0000, 1'b0};
        vecs[8]  = '{OP_RD, 16'hBF01, 16'h0000, 16'h0003, 1'b0};
        vecs[9]  = '{OP_RD, 16'hBF00, 16'h0000, 16'h00A5, 1'b0};
        vecs[10] = '{OP_RD, 16'hBF00, 16'h0000, 16'h003C, 1'b0};
        vecs[11] = '{OP_RD, 16'hBF00, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{OP_RD, 16'hBF01, 16'h0000, 16'h0001, 1'b0};

        #23;
        check("reset_txd", {15'h0, txd}, 16'h0001);
        check("reset_busy", {15'h0, tx_busy}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: reads, ignored writes, RX queueing
        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR: bus_write(vecs[i].addr, vecs[i].wdat);
                OP_RX: rx_push(vecs[i].wdat[7:0]);
                default: begin
                    bus_read(vecs[i].addr, 1, d);
                    if (vecs[i].expz) check_z($sformatf("vec%0d_rd_%h", i, vecs[i].addr), d);
                    else check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), d, vecs[i].exp);
                end
            endcase
        end
        repeat (60) @(negedge clk);
        check("ignored_writes_no_frame", 16'(rx_q.size()), 16'd0);
        check("idle_txd", {15'h0, txd}, 16'h0001);

        // Single frame: exact waveform, latency and busy width
        busy_cnt = 0;
        bus_write(16'hBF00, 16'h1255);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            txs[i] = txd;
            if (tx_busy) busy_cnt++;
        end
        first = -1;
        for (int i = 0; i < 200; i++) if (first < 0 && txs[i] == 1'b0) first = i;
        check("frame_start_latency", 16'(first), 16'd1);
        bad = 0;
        if (first >= 0) begin
            for (int j = 0; j < 41; j++) begin
                if (j < 4)       e = 1'b0;
                else if (j < 36) e = ((8'h55 >> ((j - 4) / 4)) & 8'h01) != 8'h00;
                else             e = 1'b1;
                if (txs[first + j] !== e) bad++;
            end
        end else begin
            bad = 99;
        end
        check("frame_waveform_bad_samples", 16'(bad), 16'd0);
        check("frame_busy_clocks", 16'(busy_cnt), 16'd40);
        rx_q.delete();
        stop_err = 0;

        // Back-to-back writes: one to the serializer, four buffered, one dropped
        sent = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) bus_write(16'hBF00, {8'hEE, sent[i]});
        bus_write(16'hBF00, 16'h0066);
        bus_read(16'hBF01, 1, d);
        check("status_tx_overflow", d, 16'h0004);
        bus_read(16'hBF01, 1, d);
        check("status_after_clear", d, 16'h0000);
        for (int t = 0; t < 400 && rx_q.size() < 5; t++) @(negedge clk);
        repeat (80) @(negedge clk);
        check("frame_count", 16'(rx_q.size()), 16'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check($sformatf("frame%0d_byte", i), {8'h00, rx_q[i]}, {8'h00, sent[i]});
        end
        check("stop_bit_errors", 16'(stop_err), 16'd0);
        bus_read(16'hBF01, 1, d);
        check("status_tx_drained", d, 16'h0001);

        // RX overrun and a long DATA read popping once
        for (int i = 1; i <= 5; i++) rx_push(8'(i));
        @(negedge clk);
        bus_read(16'hBF01, 1, d);
        check("status_rx_overrun", d, 16'h000B);
        bus_read(16'hBF00, 3, d);
        check("long_read_head", d, 16'h0001);
        bus_read(16'hBF01, 1, d);
        check("status_after_long_read", d, 16'h0003);
        bus_read(16'hBF00, 1, d);
        check("read_after_long_read", d, 16'h0002);

        // Reset in the middle of a data phase
        mon_en = 1'b0;
        bus_write(16'hBF00, 16'h0000);
        first = -1;
        for (int t = 0; t < 50 && first < 0; t++) begin
            @(negedge clk);
            if (txd == 1'b0) first = t;
        end
        check("mid_reset_frame_started", {15'h0, first >= 0}, 16'h0001);
        repeat (CPB + 3) @(negedge clk);
        check("mid_reset_busy_before", {15'h0, tx_busy}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_txd", {15'h0, txd}, 16'h0001);
        check("mid_reset_busy", {15'h0, tx_busy}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(16'hBF01, 1, d);
        check("status_after_reset", d, 16'h0001);
        lows = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("line_idle_after_reset", 16'(lows), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
